// File: rtl/mmio_pkg.sv
// Shared bus-command encodings, default I/O window addresses and display constants for mmio_responder.
package mmio_pkg;

   typedef enum logic [1:0] {
      MNONE  = 2'b00,
      MREAD  = 2'b01,
      MWRITE = 2'b10,
      MRSVD  = 2'b11
   } mem_cmd_t;

   localparam logic [8:0] DEF_SW_ADDR  = 9'h140;
   localparam logic [8:0] DEF_LED_ADDR = 9'h100;
   localparam logic [8:0] DEF_HEX_ADDR = 9'h120;

   localparam logic [6:0] SSEG_BLANK = 7'h7F;

endpackage

// File: rtl/sseg_decoder.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module sseg_decoder (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h7F;
      case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
   end

endmodule

// File: rtl/mmio_responder.sv
// Board I/O responder on the lab7 CPU data bus: debounced switches, LED register, optional HEX register.
// The HEX register and its four digit decoders exist only when HEX_DISPLAY_EN is defined.
module mmio_responder
   import mmio_pkg::*;
#(
   parameter int         DEBOUNCE_CYCLES = 4,
   parameter logic [8:0] SW_ADDR         = DEF_SW_ADDR,
   parameter logic [8:0] LED_ADDR        = DEF_LED_ADDR,
   parameter logic [8:0] HEX_ADDR        = DEF_HEX_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  mem_cmd,
   input  logic [8:0]  mem_addr,
   input  logic [15:0] write_data,
   output logic [15:0] read_data,
   output logic        rd_hit,
   input  logic [9:0]  SW,
   output logic [7:0]  LEDR,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [9:0]       sync1, sync2, candidate, sw_stable;
   logic [CNT_W-1:0] deb_cnt;
   logic [7:0]       led_reg;
   logic             rd_match;
   logic [15:0]      rd_value;

   // Any change at sync2 restarts the hold count; the candidate is accepted only after it stays put.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1     <= '0;
         sync2     <= '0;
         candidate <= '0;
         sw_stable <= '0;
         deb_cnt   <= '0;
      end else begin
         sync1 <= SW;
         sync2 <= sync1;
         if (sync2 != candidate) begin
            candidate <= sync2;
            deb_cnt   <= '0;
         end else if (deb_cnt < CNT_MAX) begin
            deb_cnt <= deb_cnt + 1'b1;
            if (deb_cnt == CNT_LAST)
               sw_stable <= candidate;
         end
      end
   end

`ifdef HEX_DISPLAY_EN
   logic [15:0] hex_reg;
   logic [6:0]  seg0, seg1, seg2, seg3;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         hex_reg <= '0;
      else if (mem_cmd == MWRITE && mem_addr == HEX_ADDR)
         hex_reg <= write_data;
   end

   sseg_decoder u_dig0 (.nibble(hex_reg[3:0]),   .seg(seg0));
   sseg_decoder u_dig1 (.nibble(hex_reg[7:4]),   .seg(seg1));
   sseg_decoder u_dig2 (.nibble(hex_reg[11:8]),  .seg(seg2));
   sseg_decoder u_dig3 (.nibble(hex_reg[15:12]), .seg(seg3));

   // Digits stay blank while reset is held rather than showing the cleared register as "0000".
   assign HEX0 = reset ? seg0 : SSEG_BLANK;
   assign HEX1 = reset ? seg1 : SSEG_BLANK;
   assign HEX2 = reset ? seg2 : SSEG_BLANK;
   assign HEX3 = reset ? seg3 : SSEG_BLANK;
`else
   logic unused_bits;
   assign unused_bits = &{1'b0, write_data[15:8], HEX_ADDR};

   assign HEX0 = SSEG_BLANK;
   assign HEX1 = SSEG_BLANK;
   assign HEX2 = SSEG_BLANK;
   assign HEX3 = SSEG_BLANK;
`endif

   always_comb begin
      rd_match = 1'b0;
      rd_value = '0;
      if (mem_cmd == MREAD) begin
         if (mem_addr == SW_ADDR) begin
            rd_match = 1'b1;
            rd_value = {6'b0, sw_stable};
         end else if (mem_addr == LED_ADDR) begin
            rd_match = 1'b1;
            rd_value = {8'b0, led_reg};
`ifdef HEX_DISPLAY_EN
         end else if (mem_addr == HEX_ADDR) begin
            rd_match = 1'b1;
            rd_value = hex_reg;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_reg   <= '0;
         read_data <= '0;
         rd_hit    <= 1'b0;
      end else begin
         read_data <= rd_value;
         rd_hit    <= rd_match;
         if (mem_cmd == MWRITE && mem_addr == LED_ADDR)
            led_reg <= write_data[7:0];
      end
   end

   assign LEDR = led_reg;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed plus randomized bench for mmio_responder, checked against a run-length switch model.
// Define HEX_DISPLAY_EN for both bench and RTL to exercise the HEX register.
module tb_mmio_responder;
   import mmio_pkg::*;

   localparam int DC = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] write_data;
   logic [15:0] read_data;
   logic        rd_hit;
   logic [9:0]  SW;
   logic [7:0]  LEDR;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3;

   int total = 0;
   int bad   = 0;

   logic [7:0]  m_led;
   logic [15:0] m_hex;
   logic [9:0]  m_stable;
   logic [9:0]  run_val;
   int          run_len;
   logic        dly_valid [2];
   logic [9:0]  dly_val [2];
   logic [15:0] m_rdata;
   logic        m_rhit;

   always #5 clk = ~clk;

   mmio_responder #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
      .write_data(write_data), .read_data(read_data), .rd_hit(rd_hit),
      .SW(SW), .LEDR(LEDR), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
   );

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      logic [6:0] tbl [16];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return tbl[n];
   endfunction

   function automatic logic [6:0] hex_expected(input int n);
`ifdef HEX_DISPLAY_EN
      if (!reset)
         return 7'h7F;
      return seg_of(m_hex[4*n +: 4]);
`else
      return 7'h7F;
`endif
   endfunction

   task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_led        = '0;
      m_hex        = '0;
      m_stable     = '0;
      run_val      = '0;
      run_len      = 0;
      dly_valid[0] = 1'b0;
      dly_valid[1] = 1'b0;
      dly_val[0]   = '0;
      dly_val[1]   = '0;
      m_rdata      = '0;
      m_rhit       = 1'b0;
   endtask

   // A switch value held for DC+1 consecutive samples becomes visible two edges later (synchroniser).
   task automatic modelEdge();
      m_rhit  = 1'b0;
      m_rdata = '0;
      if (mem_cmd == MREAD) begin
         if (mem_addr == 9'h140) begin
            m_rhit  = 1'b1;
            m_rdata = {6'b0, m_stable};
         end else if (mem_addr == 9'h100) begin
            m_rhit  = 1'b1;
            m_rdata = {8'b0, m_led};
`ifdef HEX_DISPLAY_EN
         end else if (mem_addr == 9'h120) begin
            m_rhit  = 1'b1;
            m_rdata = m_hex;
`endif
         end
      end
      if (mem_cmd == MWRITE) begin
         if (mem_addr == 9'h100)
            m_led = write_data[7:0];
`ifdef HEX_DISPLAY_EN
         if (mem_addr == 9'h120)
            m_hex = write_data;
`endif
      end
      if (dly_valid[1])
         m_stable = dly_val[1];
      dly_valid[1] = dly_valid[0];
      dly_val[1]   = dly_val[0];
      if (SW == run_val) begin
         run_len++;
      end else begin
         run_val = SW;
         run_len = 1;
      end
      dly_valid[0] = (run_len == DC + 1);
      dly_val[0]   = run_val;
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, "/read_data"}, read_data, m_rdata);
      checkVal({tag, "/rd_hit"}, {15'b0, rd_hit}, {15'b0, m_rhit});
      checkVal({tag, "/LEDR"}, {8'b0, LEDR}, {8'b0, m_led});
      checkVal({tag, "/HEX0"}, {9'b0, HEX0}, {9'b0, hex_expected(0)});
      checkVal({tag, "/HEX1"}, {9'b0, HEX1}, {9'b0, hex_expected(1)});
      checkVal({tag, "/HEX2"}, {9'b0, HEX2}, {9'b0, hex_expected(2)});
      checkVal({tag, "/HEX3"}, {9'b0, HEX3}, {9'b0, hex_expected(3)});
   endtask

   task automatic applyStimulus(input string tag, input logic [1:0] cmd, input logic [8:0] addr,
                                input logic [15:0] data, input logic [9:0] sw);
      mem_cmd    = cmd;
      mem_addr   = addr;
      write_data = data;
      SW         = sw;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput(tag);
   endtask

   initial begin
      logic [1:0]  cmd;
      logic [8:0]  addr;
      logic [9:0]  sw;
      mem_cmd    = MNONE;
      mem_addr   = '0;
      write_data = '0;
      SW         = '0;
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;

      applyStimulus("led_prewrite", MWRITE, 9'h100, 16'h00A5, 10'h000);
      checkVal("led_prewrite_const", {8'b0, LEDR}, 16'h00A5);

      @(negedge clk);
      SW    = 10'h3FF;
      reset = 1'b0;
      modelReset();
      #1;
      checkOutput("reset_assert");
      checkVal("reset_ledr_const", {8'b0, LEDR}, 16'h0000);
      checkVal("reset_hex0_const", {9'b0, HEX0}, 16'h007F);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_hold");
      @(negedge clk) reset = 1'b1;

      applyStimulus("sw_undebounced", MREAD, 9'h140, 16'h0, 10'h3FF);
      checkVal("sw_undebounced_const", read_data, 16'h0000);

      for (int i = 0; i < 7; i++)
         applyStimulus("sw_hold", MNONE, 9'h000, 16'h0, 10'h00F);
      applyStimulus("sw_read", MREAD, 9'h140, 16'h0, 10'h00F);
      checkVal("sw_debounced_const", read_data, 16'h000F);
      checkVal("sw_debounced_hit", {15'b0, rd_hit}, 16'h0001);

      for (int i = 0; i < 3; i++)
         applyStimulus("glitch3", MNONE, 9'h000, 16'h0, 10'h3FF);
      for (int i = 0; i < 8; i++)
         applyStimulus("after_glitch3", MREAD, 9'h140, 16'h0, 10'h00F);
      checkVal("glitch3_const", read_data, 16'h000F);

      for (int i = 0; i < 4; i++)
         applyStimulus("glitch4", MNONE, 9'h000, 16'h0, 10'h2AA);
      for (int i = 0; i < 8; i++)
         applyStimulus("after_glitch4", MREAD, 9'h140, 16'h0, 10'h00F);
      checkVal("glitch4_const", read_data, 16'h000F);

      for (int i = 0; i < 5; i++)
         applyStimulus("hold5", MNONE, 9'h000, 16'h0, 10'h155);
      for (int i = 0; i < 2; i++)
         applyStimulus("hold5_settle", MNONE, 9'h000, 16'h0, 10'h00F);
      applyStimulus("hold5_read", MREAD, 9'h140, 16'h0, 10'h00F);
      checkVal("hold5_const", read_data, 16'h0155);

      applyStimulus("led_write", MWRITE, 9'h100, 16'hBEEF, 10'h00F);
      checkVal("led_write_const", {8'b0, LEDR}, 16'h00EF);
      applyStimulus("led_read_a", MREAD, 9'h100, 16'h0, 10'h00F);
      checkVal("led_read_const", read_data, 16'h00EF);
      applyStimulus("led_read_b", MREAD, 9'h100, 16'h0, 10'h00F);
      checkVal("led_b2b_hit", {15'b0, rd_hit}, 16'h0001);

      applyStimulus("unmapped_read", MREAD, 9'h0FF, 16'h0, 10'h00F);
      checkVal("unmapped_hit_const", {15'b0, rd_hit}, 16'h0000);
      applyStimulus("sw_write", MWRITE, 9'h140, 16'hFFFF, 10'h00F);
      applyStimulus("sw_after_write", MREAD, 9'h140, 16'h0, 10'h00F);
      applyStimulus("rsvd_cmd", 2'b11, 9'h100, 16'h0000, 10'h00F);
      checkVal("rsvd_led_const", {8'b0, LEDR}, 16'h00EF);

      applyStimulus("hex_write", MWRITE, 9'h120, 16'h1234, 10'h00F);
      applyStimulus("hex_read", MREAD, 9'h120, 16'h0, 10'h00F);
`ifdef HEX_DISPLAY_EN
      checkVal("hex0_const", {9'b0, HEX0}, 16'h0019);
      checkVal("hex3_const", {9'b0, HEX3}, 16'h0079);
      checkVal("hex_read_const", read_data, 16'h1234);
`else
      checkVal("hex0_blank_const", {9'b0, HEX0}, 16'h007F);
      checkVal("hex_read_hit_const", {15'b0, rd_hit}, 16'h0000);
`endif

      sw = 10'h00F;
      for (int i = 0; i < 300; i++) begin
         cmd = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       addr = 9'h140;
            1:       addr = 9'h100;
            2:       addr = 9'h120;
            default: addr = 9'($urandom);
         endcase
         if ($urandom_range(0, 5) == 0)
            sw = 10'($urandom);
         applyStimulus("random", cmd, addr, 16'($urandom), sw);
      end

      applyStimulus("pre_abort_write", MWRITE, 9'h100, 16'h005A, sw);
      applyStimulus("abort_read", MREAD, 9'h100, 16'h0, sw);
      checkVal("abort_hit_before", {15'b0, rd_hit}, 16'h0001);
      #2;
      reset = 1'b0;
      modelReset();
      #1;
      checkVal("abort_hit_const", {15'b0, rd_hit}, 16'h0000);
      checkVal("abort_ledr_const", {8'b0, LEDR}, 16'h0000);
      checkOutput("abort");
      @(negedge clk) reset = 1'b1;
      applyStimulus("post_abort", MREAD, 9'h100, 16'h0, sw);
      for (int i = 0; i < 10; i++)
         applyStimulus("post_abort_sw", MREAD, 9'h140, 16'h0, 10'h2C3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
